uart_register_peripheral: RTL and testbench

//  Responder on the ulisp core's register bus (register_index/read/write/value). Maps a

---
 rtl/uart_register_peripheral_pkg.sv | 25 ++
 rtl/uart_register_peripheral_fifo.sv | 45 ++++
 rtl/uart_register_peripheral.sv | 212 +++++++++++++++++++++
 tb/tb_uart_register_peripheral.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_register_peripheral_pkg.sv
// Register map, status layout and UART FSM states shared by the peripheral
// and the firmware headers.
package uart_register_peripheral_pkg;

  localparam logic [11:0] REG_UART_DATA   = 12'd0;
  localparam logic [11:0] REG_UART_STATUS = 12'd1;
  localparam logic [11:0] REG_HALT        = 12'd4095;

  localparam int STAT_TX_READY    = 0;
  localparam int STAT_RX_AVAIL    = 1;
  localparam int STAT_RX_OVERRUN  = 2;
  localparam int STAT_TX_OVERFLOW = 3;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        tx_overflow;
    logic        rx_overrun;
    logic        rx_avail;
    logic        tx_ready;
  } status_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

endpackage

// File: rtl/uart_register_peripheral_fifo.sv
// Small show-ahead FIFO; pop_data is the head entry, push/pop take effect on the clock edge.
// A push while full is dropped unless a pop frees the slot in the same cycle; pop while empty is ignored.
module register_bus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_register_peripheral.sv
// Register-bus slave exposing a FIFO-buffered 8N1 UART and a sticky halt latch.
// Reads return one cycle after the strobe; full FIFOs drop bytes and raise sticky flags.
module uart_register_peripheral
  import uart_register_peripheral_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        halt
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_fifo_data, rx_fifo_data;
  logic       status_rd, tx_overflow, rx_overrun;
  status_t    status;

  tx_state_t     tx_state, tx_state_n;
  logic [TW-1:0] tx_timer, tx_timer_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;

  rx_state_t     rx_state, rx_state_n;
  logic [TW-1:0] rx_timer, rx_timer_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_s1, rx_sync, rx_prev;

  assign tx_push   = register_write && (register_index == REG_UART_DATA);
  assign rx_pop    = register_read && (register_index == REG_UART_DATA);
  assign status_rd = register_read && (register_index == REG_UART_STATUS);

  register_bus_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .push_data(register_write_value[7:0]),
    .pop(tx_pop), .pop_data(tx_fifo_data), .full(tx_full), .empty(tx_empty)
  );

  register_bus_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .pop_data(rx_fifo_data), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status             = '0;
    status.tx_overflow = tx_overflow;
    status.rx_overrun  = rx_overrun;
    status.rx_avail    = !rx_empty;
    status.tx_ready    = !tx_full;
  end

  // A flag being set in the same cycle as a status read wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_read_value <= '0;
      halt                <= 1'b0;
      tx_overflow         <= 1'b0;
      rx_overrun          <= 1'b0;
    end else begin
      if (register_read) begin
        case (register_index)
          REG_UART_DATA:   register_read_value <= rx_empty ? 16'h0000 : {8'h00, rx_fifo_data};
          REG_UART_STATUS: register_read_value <= status;
          REG_HALT:        register_read_value <= {15'h0000, halt};
          default:         register_read_value <= '0;
        endcase
      end
      if (register_write && (register_index == REG_HALT)) halt <= 1'b1;
      if (tx_push && tx_full && !tx_pop)      tx_overflow <= 1'b1;
      else if (status_rd)                     tx_overflow <= 1'b0;
      if (rx_push && rx_full && !rx_pop)      rx_overrun <= 1'b1;
      else if (status_rd)                     rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_s1    <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      rx_state <= rx_state_n;
      rx_timer <= rx_timer_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_s1    <= uart_rx;
      rx_sync  <= rx_s1;
      rx_prev  <= rx_sync;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    uart_tx    = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_timer_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_fifo_data;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0;
          tx_idx_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        uart_tx = tx_shift[0];
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_idx_n   = tx_idx + 1'b1;
          if (tx_idx == 3'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0;
          // Chain straight into the next START so back-to-back frames have no idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_fifo_data;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_timer_n = rx_timer + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_timer_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_timer == HALF_LAST) begin
          rx_timer_n = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_timer == BIT_LAST) begin
          rx_timer_n = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_idx_n   = rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_timer == BIT_LAST) begin
          rx_timer_n = '0;
          // A low stop bit silently discards the byte and waits out the break.
          if (rx_sync) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_timer_n = '0;
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_register_peripheral.sv
// Directed-plus-random bench: a serial-line monitor decodes uart_tx, a queue model tracks RX data and sticky flags.
module tb_uart_register_peripheral;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        halt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_seen = 1'b0;

  byte unsigned tx_seen[$];
  int           tx_start_t[$];
  byte unsigned tx_exp[$];
  byte unsigned rx_q[$];
  bit           m_ovf = 1'b0;
  bit           m_ovr = 1'b0;

  uart_register_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .register_index(register_index),
    .register_read(register_read), .register_write(register_write),
    .register_write_value(register_write_value), .register_read_value(register_read_value),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .halt(halt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge reset_n) rst_seen = 1'b1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial-line decoder: samples each bit near its middle, timed from the start-bit edge.
  initial begin : tx_monitor
    byte unsigned b;
    int           t0;
    logic         startb, stopb;
    forever begin
      @(negedge uart_tx);
      #1;
      t0 = cyc;
      rst_seen = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      startb = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      stopb = uart_tx;
      if (!rst_seen) begin
        check("tx_start_bit", {15'h0, startb}, 16'h0000);
        check("tx_stop_bit", {15'h0, stopb}, 16'h0001);
        tx_seen.push_back(b);
        tx_start_t.push_back(t0);
      end
    end
  end

  task automatic wr(input logic [11:0] idx, input logic [15:0] v);
    register_index = idx;
    register_write_value = v;
    register_write = 1'b1;
    @(posedge clk); #1;
    register_write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] idx, input logic [15:0] exp);
    register_index = idx;
    register_read = 1'b1;
    @(posedge clk); #1;
    register_read = 1'b0;
    check(tag, register_read_value, exp);
  endtask

  task automatic status_check(input string tag, input bit tx_ready);
    logic [15:0] exp;
    exp = {12'h000, m_ovf, m_ovr, rx_q.size() != 0, tx_ready};
    m_ovf = 1'b0;
    m_ovr = 1'b0;
    rd_check(tag, 12'd1, exp);
  endtask

  task automatic rx_read_check(input string tag);
    logic [15:0] exp;
    exp = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
    rd_check(tag, 12'd0, exp);
  endtask

  task automatic send_rx(input byte unsigned b, input bit stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk); #1;
    if (stop) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic wait_frames(input int n);
    for (int k = 0; k < 12 * CPB * (n + 1) && tx_seen.size() < n; k++) @(posedge clk);
    #1;
    check("tx_frame_count", 16'(tx_seen.size()), 16'(n));
  endtask

  initial begin : stimulus
    int           wcyc, n0;
    byte unsigned b;

    repeat (3) @(posedge clk); #1;
    check("reset_uart_tx", {15'h0, uart_tx}, 16'h0001);
    check("reset_halt", {15'h0, halt}, 16'h0000);
    check("reset_read_value", register_read_value, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk); #1;
    status_check("status_after_reset", 1'b1);

    // Single frame: 0x41 with junk in the upper byte, starting the cycle after the write.
    wr(12'd0, 16'h1241);
    wcyc = cyc;
    tx_exp.push_back(8'h41);
    wait_frames(1);
    if (tx_seen.size() >= 1) begin
      check("tx_byte_0x41", {8'h00, tx_seen[0]}, 16'h0041);
      check("tx_start_latency", 16'(tx_start_t[0] - wcyc), 16'd1);
    end
    check("tx_idle_high", {15'h0, uart_tx}, 16'h0001);

    // Burst of six: one goes straight to the shifter, four buffer, the sixth is dropped.
    repeat (CPB) @(posedge clk); #1;
    n0 = tx_seen.size();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      wr(12'd0, {8'($urandom), b});
      if (i < 5) tx_exp.push_back(b);
      else m_ovf = 1'b1;
    end
    status_check("status_tx_full_overflow", 1'b0);
    status_check("status_overflow_cleared", 1'b0);
    wait_frames(n0 + 5);
    for (int i = 0; i < 5 && n0 + i < tx_seen.size(); i++) begin
      check("tx_burst_byte", {8'h00, tx_seen[n0 + i]}, {8'h00, tx_exp[n0 + i]});
      if (i > 0) check("tx_burst_no_gap", 16'(tx_start_t[n0 + i] - tx_start_t[n0 + i - 1]), 16'(10 * CPB));
    end
    status_check("status_tx_drained", 1'b1);

    // RX directed pair.
    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b1);
    status_check("status_rx_avail", 1'b1);
    rx_read_check("rx_read_5a");
    rx_read_check("rx_read_c3");
    rx_read_check("rx_read_empty");

    // RX random round trips.
    for (int i = 0; i < 3; i++) begin
      send_rx(8'($urandom), 1'b1);
      rx_read_check("rx_random_byte");
    end

    // Framing error, glitch and overrun: only the first four good bytes survive.
    send_rx(8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        uart_rx = 1'b0;
        repeat (CPB / 2) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk); #1;
      end
      send_rx(8'($urandom), 1'b1);
    end
    status_check("status_rx_overrun", 1'b1);
    for (int i = 0; i < 4; i++) rx_read_check("rx_overrun_byte");
    rx_read_check("rx_overrun_empty");
    status_check("status_rx_cleared", 1'b1);

    // Undecoded index and halt latch.
    wr(12'd7, 16'hFFFF);
    rd_check("undecoded_read", 12'd7, 16'h0000);
    wr(12'd4095, 16'h0000);
    check("halt_set", {15'h0, halt}, 16'h0001);
    repeat (20) @(posedge clk); #1;
    check("halt_sticky", {15'h0, halt}, 16'h0001);
    rd_check("halt_read", 12'd4095, 16'h0001);

    // Reset mid-frame while more bytes are queued.
    n0 = tx_seen.size();
    wr(12'd0, 16'h0000);
    wr(12'd0, 16'h0055);
    repeat (50) @(posedge clk); #1;
    check("tx_mid_frame_low", {15'h0, uart_tx}, 16'h0000);
    reset_n = 1'b0;
    #1;
    check("reset_async_uart_tx", {15'h0, uart_tx}, 16'h0001);
    check("reset_halt_cleared", {15'h0, halt}, 16'h0000);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (25 * CPB) @(posedge clk); #1;
    check("no_frames_after_reset", 16'(tx_seen.size()), 16'(n0));
    check("tx_idle_after_reset", {15'h0, uart_tx}, 16'h0001);
    status_check("status_after_midframe_reset", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
